irq_gen_multi: RTL and testbench

Multi-source interrupt generator for the AXI-Lite register station, the parametrised successor of the single-source error IRQ stretcher. It accepts `NUM_SRC` independent error strobes and keeps a sticky pending/overflow status per source. Each source is masked and runs in either pulse (stretched, retriggerable) or level (held until software clear) mode. All sources are combined into one interrupt line, and the per-source vector is also exported for the register map.

---
 rtl/irq_pkg.sv | 19 +
 rtl/irq_src_chan.sv | 121 ++++++++++++
 rtl/irq_gen_multi.sv | 51 +++++
 tb/tb_irq_gen_multi.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and helpers for the multi-source interrupt generator.
package irq_pkg;

    typedef enum logic {
        IRQ_PULSE = 1'b0,
        IRQ_LEVEL = 1'b1
    } irq_mode_e;

    typedef enum logic {
        IRQ_IDLE = 1'b0,
        IRQ_HOLD = 1'b1
    } irq_state_e;

    // Width of a down-counter that must hold values 0..hold.
    function automatic int unsigned irq_cnt_w(input int unsigned hold);
        return $clog2(hold + 1);
    endfunction

endpackage

// File: rtl/irq_src_chan.sv
// One interrupt source: sticky pending/overflow status plus the pulse-stretch
// FSM and counter (or level follower) that drives its interrupt bit.
module irq_src_chan
    import irq_pkg::*;
#(
    parameter bit          IRQ_EN        = 1'b1,
    parameter int unsigned IRQ_HOLD_TIME = 1024
) (
    input  logic aclk,
    input  logic rst,
    input  logic error_i,
    input  logic mask_i,
    input  logic mode_i,
    input  logic clr_i,
    output logic pending_o,
    output logic ovf_o,
    output logic irq_o
);

    localparam int unsigned CNT_W = irq_cnt_w(IRQ_HOLD_TIME);

    logic pending_q, pending_d;
    logic ovf_q, ovf_d;

    // Set beats clear for pending; clear beats set for overflow.
    always_comb begin
        pending_d = error_i | (pending_q & ~clr_i);
        ovf_d     = ~clr_i & (ovf_q | (error_i & pending_q));
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            pending_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign pending_o = pending_q;
    assign ovf_o     = ovf_q;

    if (IRQ_EN) begin : g_irq
        localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IRQ_HOLD_TIME - 1);

        irq_state_e       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             irq_q, irq_d;
        logic             trig;
        logic             level_mode;

        assign trig       = error_i & mask_i;
        assign level_mode = (irq_mode_e'(mode_i) == IRQ_LEVEL);

        always_ff @(posedge aclk or posedge rst) begin
            if (rst) begin
                state_q <= IRQ_IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Level mode parks the stretcher, so a mode switch discards any hold.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            if (level_mode) begin
                state_d = IRQ_IDLE;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    IRQ_IDLE: begin
                        if (trig) begin
                            state_d = IRQ_HOLD;
                            cnt_d   = CNT_LOAD;
                        end
                    end
                    IRQ_HOLD: begin
                        if (trig) begin
                            cnt_d = CNT_LOAD;
                        end else if (clr_i || !mask_i) begin
                            state_d = IRQ_IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == '0) begin
                            state_d = IRQ_IDLE;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                endcase
            end
        end

        always_comb begin
            irq_d = 1'b0;
            if (level_mode) begin
                irq_d = pending_d & mask_i;
            end else begin
                irq_d = (state_d == IRQ_HOLD);
            end
        end

        always_ff @(posedge aclk or posedge rst) begin
            if (rst) begin
                irq_q <= 1'b0;
            end else begin
                irq_q <= irq_d;
            end
        end

        assign irq_o = irq_q;
    end else begin : g_no_irq
        logic unused_c;
        assign unused_c = ^{mask_i, mode_i};
        assign irq_o    = 1'b0;
    end

endmodule

// File: rtl/irq_gen_multi.sv
// Multi-source interrupt generator: one channel per error source, combined
// into a single interrupt line.
module irq_gen_multi
    import irq_pkg::*;
#(
    parameter int unsigned NUM_SRC       = 4,
    parameter bit          IRQ_EN        = 1'b1,
    parameter int unsigned IRQ_HOLD_TIME = 1024
) (
    input  logic               aclk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] error_i,
    input  logic [NUM_SRC-1:0] mask_i,
    input  logic [NUM_SRC-1:0] mode_i,
    input  logic [NUM_SRC-1:0] clr_i,
    output logic [NUM_SRC-1:0] pending_o,
    output logic [NUM_SRC-1:0] ovf_o,
    output logic [NUM_SRC-1:0] irq_vec_o,
    output logic               irq_o
);

    if (IRQ_HOLD_TIME < 1) begin : g_bad_hold
        $error("irq_gen_multi: IRQ_HOLD_TIME must be at least 1");
    end
    if (NUM_SRC < 1 || NUM_SRC > 32) begin : g_bad_num
        $error("irq_gen_multi: NUM_SRC must be in 1..32");
    end

    logic [NUM_SRC-1:0] chan_irq;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        irq_src_chan #(
            .IRQ_EN        (IRQ_EN),
            .IRQ_HOLD_TIME (IRQ_HOLD_TIME)
        ) u_chan (
            .aclk      (aclk),
            .rst       (rst),
            .error_i   (error_i[i]),
            .mask_i    (mask_i[i]),
            .mode_i    (mode_i[i]),
            .clr_i     (clr_i[i]),
            .pending_o (pending_o[i]),
            .ovf_o     (ovf_o[i]),
            .irq_o     (chan_irq[i])
        );
    end

    assign irq_vec_o = IRQ_EN ? chan_irq : '0;
    assign irq_o     = |irq_vec_o;

endmodule

// File: tb/tb_irq_gen_multi.sv
// Bench for irq_gen_multi: directed scenarios plus random traffic against a
// deadline-based behavioural model, with an IRQ_EN=0 build alongside.
module tb_irq_gen_multi;

    localparam int unsigned N = 4;
    localparam int unsigned H = 8;

    logic         aclk = 1'b0;
    logic         rst  = 1'b1;
    logic [N-1:0] error_i = '0, mask_i = '0, mode_i = '0, clr_i = '0;
    logic [N-1:0] pend, ovf, vec;
    logic         irq;
    logic [N-1:0] pend_off, ovf_off, vec_off;
    logic         irq_off;

    always #5 aclk = ~aclk;

    irq_gen_multi #(.NUM_SRC(N), .IRQ_EN(1'b1), .IRQ_HOLD_TIME(H)) dut (
        .aclk(aclk), .rst(rst), .error_i(error_i), .mask_i(mask_i),
        .mode_i(mode_i), .clr_i(clr_i), .pending_o(pend), .ovf_o(ovf),
        .irq_vec_o(vec), .irq_o(irq)
    );

    irq_gen_multi #(.NUM_SRC(N), .IRQ_EN(1'b0), .IRQ_HOLD_TIME(H)) dut_off (
        .aclk(aclk), .rst(rst), .error_i(error_i), .mask_i(mask_i),
        .mode_i(mode_i), .clr_i(clr_i), .pending_o(pend_off), .ovf_o(ovf_off),
        .irq_vec_o(vec_off), .irq_o(irq_off)
    );

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: a pulse source is high after edge e while e < deadline.
    bit     m_pend[N], m_ovf[N], m_vec[N];
    longint m_deadline[N];
    longint m_edge = 0;

    always @(posedge aclk) begin
        logic e, c, m, md, pn;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                m_pend[i] = 1'b0; m_ovf[i] = 1'b0; m_vec[i] = 1'b0; m_deadline[i] = 0;
            end else begin
                e = error_i[i]; c = clr_i[i]; m = mask_i[i]; md = mode_i[i];
                m_ovf[i]  = !c && (m_ovf[i] || (e && m_pend[i]));
                pn        = e || (m_pend[i] && !c);
                m_pend[i] = pn;
                if (md) begin
                    m_deadline[i] = 0;
                    m_vec[i]      = pn && m;
                end else begin
                    if (e && m) m_deadline[i] = m_edge + H;
                    else if (m_deadline[i] > m_edge && (c || !m)) m_deadline[i] = m_edge;
                    m_vec[i] = (m_edge < m_deadline[i]);
                end
            end
        end
        m_edge++;
    end

    always @(posedge aclk) begin
        logic [N-1:0] ep, eo, ev;
        #2;
        if (!done) begin
            for (int i = 0; i < N; i++) begin
                ep[i] = m_pend[i]; eo[i] = m_ovf[i]; ev[i] = m_vec[i];
            end
            chk("pending", 32'(pend), 32'(ep));
            chk("ovf", 32'(ovf), 32'(eo));
            chk("irq_vec", 32'(vec), 32'(ev));
            chk("irq", 32'(irq), 32'(|ev));
            chk("off_pending", 32'(pend_off), 32'(ep));
            chk("off_ovf", 32'(ovf_off), 32'(eo));
            chk("off_irq_vec", 32'(vec_off), 32'd0);
            chk("off_irq", 32'(irq_off), 32'd0);
        end
    end

    task automatic drive(input logic [N-1:0] e, input logic [N-1:0] c);
        error_i = e;
        clr_i   = c;
        @(negedge aclk);
        error_i = '0;
        clr_i   = '0;
    endtask

    task automatic count_high(input int b, output int n);
        n = 0;
        while (vec[b] && n < 100) begin
            n++;
            drive('0, '0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, hi;
        logic [N-1:0] r;

        repeat (3) @(negedge aclk);
        chk("rst_vec", 32'(vec), 32'd0);
        chk("rst_pend", 32'(pend), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge aclk);
        chk("idle_irq", 32'(irq), 32'd0);

        // Single pulse on src0.
        mask_i = 4'b0001; mode_i = 4'b0000;
        drive(4'b0001, '0);
        chk("pulse_irq", 32'(irq), 32'd1);
        chk("off_pend0", 32'(pend_off[0]), 32'd1);
        count_high(0, n);
        chk("pulse_len", 32'(n), 32'(H));
        chk("pulse_pend", 32'(pend[0]), 32'd1);
        drive('0, 4'b0001);
        chk("pulse_clr", 32'(pend[0]), 32'd0);

        // Retrigger at cycle 5.
        hi = 0;
        drive(4'b0001, '0);
        if (vec[0]) hi++;
        repeat (4) begin
            drive('0, '0);
            if (vec[0]) hi++;
        end
        drive(4'b0001, '0);
        chk("retrig_ovf", 32'(ovf[0]), 32'd1);
        count_high(0, n);
        chk("retrig_len", 32'(hi + n), 32'(5 + H));
        drive('0, 4'b0001);
        chk("retrig_clr", 32'({pend[0], ovf[0]}), 32'd0);

        // Level mode on src2.
        mode_i = 4'b0100; mask_i = 4'b0001;
        drive(4'b0100, '0);
        chk("lvl_pend", 32'(pend[2]), 32'd1);
        chk("lvl_masked", 32'(vec[2]), 32'd0);
        mask_i = 4'b0101;
        drive('0, '0);
        chk("lvl_unmask", 32'(vec[2]), 32'd1);
        drive(4'b0100, 4'b0100);
        chk("lvl_setwin", 32'(pend[2]), 32'd1);
        chk("lvl_ovf0", 32'(ovf[2]), 32'd0);
        drive('0, 4'b0100);
        chk("lvl_clr", 32'(vec[2]), 32'd0);

        // All sources, mixed modes.
        mode_i = 4'b0101; mask_i = 4'b1111;
        drive(4'b1111, '0);
        chk("mix_all", 32'(vec), 32'hf);
        chk("off_mix_vec", 32'(vec_off), 32'd0);
        drive('0, '0);
        drive('0, '0);
        drive('0, 4'b0010);
        chk("mix_clr1", 32'(vec), 32'hd);
        drive('0, 4'b0101);
        chk("mix_clr02", 32'(vec), 32'h8);
        repeat (3) drive('0, '0);
        chk("mix_last_hi", 32'(irq), 32'd1);
        drive('0, '0);
        chk("mix_last_lo", 32'(irq), 32'd0);
        drive('0, 4'b1111);

        // Async reset mid-hold.
        mode_i = 4'b0000;
        drive(4'b0010, '0);
        chk("rh_on", 32'(vec[1]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rh_vec", 32'(vec), 32'd0);
        chk("rh_pend", 32'(pend), 32'd0);
        chk("rh_irq", 32'(irq), 32'd0);
        @(negedge aclk);
        rst = 1'b0;

        // Random traffic.
        repeat (1500) begin
            for (int i = 0; i < N; i++) begin
                r[i] = ($urandom_range(0, 3) == 0);
            end
            error_i = r;
            for (int i = 0; i < N; i++) begin
                r[i] = ($urandom_range(0, 7) == 0);
            end
            clr_i = r;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) mask_i[i] = ~mask_i[i];
                if ($urandom_range(0, 63) == 0) mode_i[i] = ~mode_i[i];
            end
            rst = ($urandom_range(0, 299) == 0);
            @(negedge aclk);
        end
        rst = 1'b0; error_i = '0; clr_i = '0;
        repeat (2) @(negedge aclk);

        done = 1'b1;
        @(negedge aclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
